// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: two-entry (main + skid) registered pipeline stage between
// an instruction-fetch producer and a decode consumer. Every output comes
// straight from a flop; the skid entry absorbs the one extra beat that can
// arrive while the registered ready is still high.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to build the saturating
// back-pressure counter on stall_cnt; otherwise stall_cnt is tied to zero.
module pipe_stage_skid #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               if_valid_in,
    input  logic [INSTR_W-1:0] if_idata_in,
    input  logic [PC_W-1:0]    if_pc_in,
    output logic               if_ready_out,
    output logic               id_valid_out,
    output logic [INSTR_W-1:0] id_idata_out,
    output logic [PC_W-1:0]    id_pc_out,
    input  logic               id_ready_in,
    output logic [31:0]        stall_cnt
);

    logic               main_valid_r, main_valid_s;
    logic [INSTR_W-1:0] main_idata_r, main_idata_s;
    logic [PC_W-1:0]    main_pc_r,    main_pc_s;
    logic               skid_valid_r, skid_valid_s;
    logic [INSTR_W-1:0] skid_idata_r, skid_idata_s;
    logic [PC_W-1:0]    skid_pc_r,    skid_pc_s;
    logic               ready_r,      ready_s;
    logic               in_xfer_s;
    logic               main_free_s;

    // Next-state selection for both entries; skid always refills main first.
    always_comb begin
        main_valid_s = main_valid_r;
        main_idata_s = main_idata_r;
        main_pc_s    = main_pc_r;
        skid_valid_s = skid_valid_r;
        skid_idata_s = skid_idata_r;
        skid_pc_s    = skid_pc_r;
        in_xfer_s    = if_valid_in & ready_r;
        main_free_s  = ~main_valid_r | id_ready_in;
        if (flush) begin
            // Drop everything held plus any same-cycle input; a coincident
            // output transfer has already been taken by the consumer.
            main_valid_s = 1'b0;
            main_idata_s = NOP_INSTR;
            main_pc_s    = '0;
            skid_valid_s = 1'b0;
        end else if (skid_valid_r) begin
            // Input is blocked here (ready is low); only drain is possible.
            if (id_ready_in) begin
                main_valid_s = 1'b1;
                main_idata_s = skid_idata_r;
                main_pc_s    = skid_pc_r;
                skid_valid_s = 1'b0;
            end else begin
                skid_valid_s = 1'b1;
            end
        end else if (main_free_s) begin
            if (in_xfer_s) begin
                main_valid_s = 1'b1;
                main_idata_s = if_idata_in;
                main_pc_s    = if_pc_in;
            end else begin
                main_valid_s = 1'b0;
                main_idata_s = NOP_INSTR;
                main_pc_s    = '0;
            end
        end else begin
            // Main is held by back-pressure: a new beat overflows into skid.
            if (in_xfer_s) begin
                skid_valid_s = 1'b1;
                skid_idata_s = if_idata_in;
                skid_pc_s    = if_pc_in;
            end else begin
                skid_valid_s = 1'b0;
            end
        end
        ready_s = ~skid_valid_s;
    end

    // State registers for main, skid and the registered upstream ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_idata_r <= NOP_INSTR;
            main_pc_r    <= '0;
            skid_valid_r <= 1'b0;
            skid_idata_r <= NOP_INSTR;
            skid_pc_r    <= '0;
            ready_r      <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            main_idata_r <= main_idata_s;
            main_pc_r    <= main_pc_s;
            skid_valid_r <= skid_valid_s;
            skid_idata_r <= skid_idata_s;
            skid_pc_r    <= skid_pc_s;
            ready_r      <= ready_s;
        end
    end

    assign if_ready_out = ready_r;
    assign id_valid_out = main_valid_r;
    assign id_idata_out = main_idata_r;
    assign id_pc_out    = main_pc_r;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Count cycles where a valid entry is refused downstream; saturates and
    // deliberately ignores flush so the statistic survives pipeline flushes.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (main_valid_r && !id_ready_in && (stall_cnt_r != 32'hFFFFFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vectors with literal expectations plus
// an occupancy-queue model compared against the DUT every cycle.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid_in = 1'b0;
    logic [31:0] if_idata_in = 32'd0;
    logic [31:0] if_pc_in = 32'd0;
    logic        if_ready_out;
    logic        id_valid_out;
    logic [31:0] id_idata_out;
    logic [31:0] id_pc_out;
    logic        id_ready_in = 1'b1;
    logic [31:0] stall_cnt;

    // second instance with non-default widths and bubble encoding
    logic        v2 = 1'b0;
    logic [15:0] idata2 = 16'd0;
    logic [63:0] pc2 = 64'd0;
    logic        rdy2_out;
    logic        valid2_out;
    logic [15:0] idata2_out;
    logic [63:0] pc2_out;
    logic [31:0] stall2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid_in(if_valid_in), .if_idata_in(if_idata_in), .if_pc_in(if_pc_in),
        .if_ready_out(if_ready_out), .id_valid_out(id_valid_out),
        .id_idata_out(id_idata_out), .id_pc_out(id_pc_out),
        .id_ready_in(id_ready_in), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.PC_W(64), .INSTR_W(16), .NOP_INSTR(16'h0001)) dut2 (
        .clk(clk), .reset(reset), .flush(1'b0),
        .if_valid_in(v2), .if_idata_in(idata2), .if_pc_in(pc2),
        .if_ready_out(rdy2_out), .id_valid_out(valid2_out),
        .id_idata_out(idata2_out), .id_pc_out(pc2_out),
        .id_ready_in(1'b1), .stall_cnt(stall2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: ordered list of held entries -----
    logic [31:0] m_pc[$];
    logic [31:0] m_id[$];
    logic        m_ready = 1'b1;
    logic [31:0] m_stall = 32'd0;
    bit          started = 0;

    always @(posedge clk) begin
        bit do_out, do_in;
        started = 1;
        if (reset) begin
            m_pc.delete(); m_id.delete();
            m_ready = 1'b1;
            m_stall = 32'd0;
        end else begin
            do_out = (m_pc.size() > 0) && id_ready_in;
            do_in  = if_valid_in && m_ready;
            if ((m_pc.size() > 0) && !id_ready_in && (m_stall != 32'hFFFFFFFF))
                m_stall = m_stall + 32'd1;
            if (flush) begin
                m_pc.delete(); m_id.delete();
                m_ready = 1'b1;
            end else begin
                if (do_out) begin
                    void'(m_pc.pop_front());
                    void'(m_id.pop_front());
                end
                if (do_in) begin
                    m_pc.push_back(if_pc_in);
                    m_id.push_back(if_idata_in);
                end
                m_ready = (m_pc.size() < 2);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    logic [31:0] dut_emitted[$];
    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", {63'd0, id_valid_out}, {63'd0, (m_pc.size() > 0)});
            chk("m_idata", {32'd0, id_idata_out}, {32'd0, (m_pc.size() > 0) ? m_id[0] : 32'h00000013});
            chk("m_pc",    {32'd0, id_pc_out},    {32'd0, (m_pc.size() > 0) ? m_pc[0] : 32'd0});
            chk("m_ready", {63'd0, if_ready_out}, {63'd0, m_ready});
`ifdef PIPE_STAGE_STALL_CNT_EN
            chk("m_stall", {32'd0, stall_cnt}, {32'd0, m_stall});
`else
            chk("m_stall", {32'd0, stall_cnt}, 64'd0);
`endif
            if (id_valid_out && id_ready_in && !reset)
                dut_emitted.push_back(id_pc_out);
        end
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rst);
        if_valid_in = v;
        if_pc_in    = pc;
        if_idata_in = pc + 32'h1000_0000;
        id_ready_in = rdy;
        flush       = fl;
        reset       = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        // reset held 2 cycles with valid input present
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", {63'd0, id_valid_out}, 64'd0);
        chk("rst_idata", {32'd0, id_idata_out}, 64'h13);
        chk("rst_pc",    {32'd0, id_pc_out},    64'd0);
        chk("rst_ready", {63'd0, if_ready_out}, 64'd1);
        chk("rst_stall", {32'd0, stall_cnt},    64'd0);
        chk("p_rst_idata", {48'd0, idata2_out}, 64'h0001);

        // streaming
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("str_pc0", {32'd0, id_pc_out}, 64'h0);
        chk("str_v0",  {63'd0, id_valid_out}, 64'd1);
        step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
        chk("str_pc4", {32'd0, id_pc_out}, 64'h4);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
        chk("str_pc8", {32'd0, id_pc_out}, 64'h8);
        chk("str_idata8", {32'd0, id_idata_out}, 64'h1000_0008);
        chk("str_ready", {63'd0, if_ready_out}, 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("str_empty", {32'd0, id_idata_out}, 64'h13);

        // back-pressure into skid
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
        chk("bp_main", {32'd0, id_pc_out}, 64'h10);
        chk("bp_ready", {63'd0, if_ready_out}, 64'd0);
        step(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", {32'd0, id_pc_out}, 64'h10);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_skid", {32'd0, id_pc_out}, 64'h14);
        chk("bp_ready1", {63'd0, if_ready_out}, 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp_drain", {63'd0, id_valid_out}, 64'd0);

        // flush with skid full and a same-cycle input
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h28, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", {63'd0, id_valid_out}, 64'd0);
        chk("fl_idata", {32'd0, id_idata_out}, 64'h13);
        chk("fl_pc",    {32'd0, id_pc_out},    64'd0);
        chk("fl_ready", {63'd0, if_ready_out}, 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        bad = 0;
        foreach (dut_emitted[i])
            if (dut_emitted[i] == 32'h20 || dut_emitted[i] == 32'h24 || dut_emitted[i] == 32'h28)
                bad++;
        chk("fl_noemit", bad, 64'd0);

        // flush coinciding with an output transfer
        step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flo_last", {32'd0, dut_emitted[dut_emitted.size()-1]}, 64'h30);

        // reset mid-stall with skid full
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h48, 1'b0, 1'b1, 1'b1);
        chk("rs_valid", {63'd0, id_valid_out}, 64'd0);
        chk("rs_ready", {63'd0, if_ready_out}, 64'd1);

        // stall counter: 5 stalled cycles after a fresh reset
        step(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("stall5", {32'd0, stall_cnt}, 64'd5);
        dut.stall_cnt_r = 32'hFFFFFFFD;
        m_stall = 32'hFFFFFFFD;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_sat", {32'd0, stall_cnt}, 64'hFFFFFFFF);
`else
        chk("stall_off", {32'd0, stall_cnt}, 64'd0);
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // wide-parameter instance pass-through
        v2 = 1'b1; pc2 = 64'h8000_0000_0000_0004; idata2 = 16'hBEEF;
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        v2 = 1'b0;
        chk("p_pc",    pc2_out, 64'h8000_0000_0000_0004);
        chk("p_idata", {48'd0, idata2_out}, 64'hBEEF);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("p_bubble", {48'd0, idata2_out}, 64'h0001);
        chk("p_valid0", {63'd0, valid2_out}, 64'd0);

        // mixed traffic checked by the model
        for (int i = 0; i < 300; i++)
            step(1'(($urandom % 2)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0), 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
